// File: rtl/rip_lsu_pkg.sv
// Shared constants and types for the data-memory load/store controller.
package rip_lsu_pkg;

    // RV32 funct3 encodings for loads and stores.
    localparam logic [2:0] F3_B  = 3'b000;
    localparam logic [2:0] F3_H  = 3'b001;
    localparam logic [2:0] F3_W  = 3'b010;
    localparam logic [2:0] F3_BU = 3'b100;
    localparam logic [2:0] F3_HU = 3'b101;

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_LOAD  = 2'd1,
        ST_MERGE = 2'd2,
        ST_RESP  = 2'd3
    } lsu_state_e;

endpackage

// File: rtl/rip_lsu_align.sv
// Combinational lane logic: load extract/extend, store merge, access check.
module rip_lsu_align
    import rip_lsu_pkg::*;
(
    input  logic        chk_we,
    input  logic [2:0]  chk_funct3,
    input  logic [1:0]  chk_off,
    input  logic [2:0]  funct3,
    input  logic [1:0]  off,
    input  logic [31:0] word,
    input  logic [15:0] wdata,
    output logic [31:0] ld_data,
    output logic [31:0] st_data,
    output logic        err
);

    logic [7:0]  ld_byte;
    logic [15:0] ld_half;

    // Pick the addressed lane and extend it to 32 bits.
    always_comb begin
        ld_byte = word[{off, 3'b000} +: 8];
        ld_half = off[1] ? word[31:16] : word[15:0];
        case (funct3)
            F3_B:    ld_data = {{24{ld_byte[7]}}, ld_byte};
            F3_H:    ld_data = {{16{ld_half[15]}}, ld_half};
            F3_BU:   ld_data = {24'h0, ld_byte};
            F3_HU:   ld_data = {16'h0, ld_half};
            default: ld_data = word;
        endcase
    end

    // Replace the addressed byte/half of the old word with store data.
    always_comb begin
        st_data = word;
        case (funct3)
            F3_B:    st_data[{off, 3'b000} +: 8]   = wdata[7:0];
            F3_H:    st_data[{off[1], 4'b0000} +: 16] = wdata;
            default: st_data = word;
        endcase
    end

    // Flag misaligned halves/words and funct3 codes not legal for the direction.
    always_comb begin
        case (chk_funct3)
            F3_B:    err = 1'b0;
            F3_H:    err = chk_off[0];
            F3_W:    err = (chk_off != 2'b00);
            F3_BU:   err = chk_we;
            F3_HU:   err = chk_we | chk_off[0];
            default: err = 1'b1;
        endcase
    end

endmodule

// File: rtl/rip_dmem_rmw_ctrl.sv
// Load/store controller for RAM port 1: byte/half stores via read-modify-write.
module rip_dmem_rmw_ctrl
    import rip_lsu_pkg::*;
#(
    parameter int ADDR_WIDTH = 10
) (
    input  logic                  clk,
    input  logic                  rstn,
    input  logic                  req_valid,
    output logic                  req_ready,
    input  logic                  req_we,
    input  logic [2:0]            req_funct3,
    input  logic [31:0]           req_addr,
    input  logic [31:0]           req_wdata,
    output logic                  rsp_valid,
    input  logic                  rsp_ready,
    output logic [31:0]           rsp_rdata,
    output logic                  rsp_err,
    output logic                  mem_enable,
    output logic                  mem_we,
    output logic [ADDR_WIDTH-1:0] mem_addr,
    output logic [31:0]           mem_din,
    input  logic [31:0]           mem_dout
);

    lsu_state_e            state_q, state_d;
    logic [ADDR_WIDTH-1:0] addr_q, addr_d;
    logic [2:0]            f3_q, f3_d;
    logic [1:0]            off_q, off_d;
    logic [15:0]           wdata_q, wdata_d;
    logic [31:0]           rdata_q, rdata_d;
    logic                  err_q, err_d;

    logic [31:0] ld_data, st_data;
    logic        req_err;
    logic        accept;

    // Upper byte-address bits beyond the RAM depth simply wrap.
    logic unused_addr;
    assign unused_addr = ^req_addr[31:ADDR_WIDTH+2];

    rip_lsu_align u_align (
        .chk_we     (req_we),
        .chk_funct3 (req_funct3),
        .chk_off    (req_addr[1:0]),
        .funct3     (f3_q),
        .off        (off_q),
        .word       (mem_dout),
        .wdata      (wdata_q),
        .ld_data    (ld_data),
        .st_data    (st_data),
        .err        (req_err)
    );

    // Gating with rstn keeps the request channel closed while held in reset.
    assign req_ready = (state_q == ST_IDLE) && rstn;
    assign accept    = req_valid && req_ready;
    assign rsp_valid = (state_q == ST_RESP);
    assign rsp_rdata = rdata_q;
    assign rsp_err   = err_q;

    // Next-state and RAM port-1 drive.
    always_comb begin
        state_d    = state_q;
        addr_d     = addr_q;
        f3_d       = f3_q;
        off_d      = off_q;
        wdata_d    = wdata_q;
        rdata_d    = rdata_q;
        err_d      = err_q;
        mem_enable = 1'b0;
        mem_we     = 1'b0;
        mem_addr   = '0;
        mem_din    = '0;
        case (state_q)
            ST_IDLE: begin
                if (accept) begin
                    rdata_d = '0;
                    err_d   = 1'b0;
                    if (req_err) begin
                        err_d   = 1'b1;
                        state_d = ST_RESP;
                    end else if (req_we && req_funct3 == F3_W) begin
                        mem_enable = 1'b1;
                        mem_we     = 1'b1;
                        mem_addr   = req_addr[ADDR_WIDTH+1:2];
                        mem_din    = req_wdata;
                        state_d    = ST_RESP;
                    end else begin
                        // Read the line now; loads extract it, sub-word stores merge it.
                        mem_enable = 1'b1;
                        mem_addr   = req_addr[ADDR_WIDTH+1:2];
                        addr_d     = req_addr[ADDR_WIDTH+1:2];
                        f3_d       = req_funct3;
                        off_d      = req_addr[1:0];
                        wdata_d    = req_wdata[15:0];
                        state_d    = req_we ? ST_MERGE : ST_LOAD;
                    end
                end
            end
            ST_LOAD: begin
                rdata_d = ld_data;
                state_d = ST_RESP;
            end
            ST_MERGE: begin
                mem_enable = 1'b1;
                mem_we     = 1'b1;
                mem_addr   = addr_q;
                mem_din    = st_data;
                state_d    = ST_RESP;
            end
            ST_RESP: begin
                if (rsp_ready) state_d = ST_IDLE;
            end
            default: state_d = ST_IDLE;
        endcase
    end

    // State and datapath registers, cleared asynchronously.
    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            state_q <= ST_IDLE;
            addr_q  <= '0;
            f3_q    <= '0;
            off_q   <= '0;
            wdata_q <= '0;
            rdata_q <= '0;
            err_q   <= 1'b0;
        end else begin
            state_q <= state_d;
            addr_q  <= addr_d;
            f3_q    <= f3_d;
            off_q   <= off_d;
            wdata_q <= wdata_d;
            rdata_q <= rdata_d;
            err_q   <= err_d;
        end
    end

endmodule

// File: tb/tb_rip_dmem_rmw_ctrl.sv
// Directed bench for rip_dmem_rmw_ctrl with a behavioural read-first RAM.
module tb_rip_dmem_rmw_ctrl;

    localparam int AW = 10;

    logic          clk = 1'b0;
    logic          rstn;
    logic          req_valid, req_ready, req_we;
    logic [2:0]    req_funct3;
    logic [31:0]   req_addr, req_wdata;
    logic          rsp_valid, rsp_ready, rsp_err;
    logic [31:0]   rsp_rdata;
    logic          mem_enable, mem_we;
    logic [AW-1:0] mem_addr;
    logic [31:0]   mem_din, mem_dout;

    int vec = 0;
    int errs = 0;
    int we_cnt = 0;
    int en_cnt = 0;

    logic [31:0] ram [0:(1<<AW)-1];

    always #5 clk = ~clk;

    rip_dmem_rmw_ctrl #(.ADDR_WIDTH(AW)) dut (
        .clk(clk), .rstn(rstn),
        .req_valid(req_valid), .req_ready(req_ready), .req_we(req_we),
        .req_funct3(req_funct3), .req_addr(req_addr), .req_wdata(req_wdata),
        .rsp_valid(rsp_valid), .rsp_ready(rsp_ready), .rsp_rdata(rsp_rdata),
        .rsp_err(rsp_err), .mem_enable(mem_enable), .mem_we(mem_we),
        .mem_addr(mem_addr), .mem_din(mem_din), .mem_dout(mem_dout)
    );

    // Read-first, 1-cycle latency RAM port.
    always @(posedge clk) begin
        if (mem_enable) begin
            mem_dout <= ram[mem_addr];
            if (mem_we) ram[mem_addr] <= mem_din;
        end
    end

    always @(negedge clk) begin
        if (mem_we) we_cnt++;
        if (mem_enable) en_cnt++;
    end

    // Present a request and wait for the accept edge; returns the accept-cycle RAM drive.
    task automatic do_req(input logic we, input logic [2:0] f3, input logic [31:0] addr,
                          input logic [31:0] wd, output logic en, output logic wen,
                          output logic [31:0] din, output logic [AW-1:0] ma);
        int n = 0;
        req_we = we; req_funct3 = f3; req_addr = addr; req_wdata = wd; req_valid = 1'b1;
        #1;
        while (!req_ready && n < 20) begin
            @(posedge clk); #1; n++;
        end
        en = mem_enable; wen = mem_we; din = mem_din; ma = mem_addr;
        @(posedge clk); #1;
        req_valid = 1'b0;
    endtask

    // Count cycles from accept to rsp_valid, capture the response, then consume it.
    task automatic wait_rsp(output int lat, output logic [31:0] rd, output logic er);
        lat = 1;
        while (!rsp_valid && lat < 20) begin
            @(posedge clk); #1; lat++;
        end
        if (!rsp_valid) lat = 99;
        rd = rsp_rdata; er = rsp_err;
        rsp_ready = 1'b1;
        @(posedge clk); #1;
        rsp_ready = 1'b0;
    endtask

    task automatic test_reset();
        rstn = 1'b0;
        req_valid = 0; req_we = 0; req_funct3 = 0; req_addr = 0; req_wdata = 0; rsp_ready = 0;
        for (int i = 0; i < (1<<AW); i++) ram[i] = 32'h0;
        mem_dout = 32'h0;
        repeat (2) @(posedge clk);
        #1;
        vec++;
        if ({rsp_valid, req_ready, mem_enable, mem_we, rsp_err} !== 5'b0 || rsp_rdata !== 32'h0) begin
            errs++;
            $display("FAIL reset: valid=%b ready=%b en=%b we=%b err=%b rdata=%h, want all 0",
                     rsp_valid, req_ready, mem_enable, mem_we, rsp_err, rsp_rdata);
        end
        rstn = 1'b1;
        @(posedge clk); #1;
        vec++;
        if (req_ready !== 1'b1) begin
            errs++; $display("FAIL reset_ready: req_ready=%b, want 1", req_ready);
        end
    endtask

    task automatic test_sw_lw();
        logic en, wen, er; logic [31:0] din, rd; logic [AW-1:0] ma; int lat;
        do_req(1'b1, 3'b010, 32'h10, 32'hDEADBEEF, en, wen, din, ma);
        vec++;
        if ({en, wen} !== 2'b11 || din !== 32'hDEADBEEF || ma !== 10'd4) begin
            errs++; $display("FAIL sw_accept: en=%b we=%b din=%h addr=%0d, want 1 1 deadbeef 4", en, wen, din, ma);
        end
        wait_rsp(lat, rd, er);
        vec++;
        if (lat != 1 || er !== 1'b0 || rd !== 32'h0) begin
            errs++; $display("FAIL sw_rsp: lat=%0d err=%b rdata=%h, want 1 0 0", lat, er, rd);
        end
        do_req(1'b0, 3'b010, 32'h10, 32'h0, en, wen, din, ma);
        vec++;
        if ({en, wen} !== 2'b10 || ma !== 10'd4) begin
            errs++; $display("FAIL lw_accept: en=%b we=%b addr=%0d, want 1 0 4", en, wen, ma);
        end
        wait_rsp(lat, rd, er);
        vec++;
        if (lat != 2 || er !== 1'b0 || rd !== 32'hDEADBEEF) begin
            errs++; $display("FAIL lw_rsp: lat=%0d err=%b rdata=%h, want 2 0 deadbeef", lat, er, rd);
        end
    endtask

    task automatic test_sb_merge();
        logic en, wen, er; logic [31:0] din, rd; logic [AW-1:0] ma; int lat; int w0;
        w0 = we_cnt;
        do_req(1'b1, 3'b000, 32'h11, 32'h123456AA, en, wen, din, ma);
        vec++;
        if ({en, wen} !== 2'b10) begin
            errs++; $display("FAIL sb_accept: en=%b we=%b, want 1 0", en, wen);
        end
        vec++;
        if (mem_we !== 1'b1 || mem_din !== 32'hDEADAAEF || mem_addr !== 10'd4) begin
            errs++; $display("FAIL sb_merge: we=%b din=%h addr=%0d, want 1 deadaaef 4", mem_we, mem_din, mem_addr);
        end
        wait_rsp(lat, rd, er);
        vec++;
        if (lat != 2 || er !== 1'b0 || rd !== 32'h0 || (we_cnt - w0) != 1) begin
            errs++; $display("FAIL sb_rsp: lat=%0d err=%b rdata=%h we_pulses=%0d, want 2 0 0 1", lat, er, rd, we_cnt - w0);
        end
        do_req(1'b0, 3'b010, 32'h10, 32'h0, en, wen, din, ma);
        wait_rsp(lat, rd, er);
        vec++;
        if (rd !== 32'hDEADAAEF) begin
            errs++; $display("FAIL sb_readback: rdata=%h, want deadaaef", rd);
        end
    endtask

    task automatic test_sub_loads();
        logic en, wen, er; logic [31:0] din, rd; logic [AW-1:0] ma; int lat;
        logic [2:0]  f3s [4] = '{3'b000, 3'b100, 3'b001, 3'b101};
        logic [31:0] ads [4] = '{32'h13, 32'h13, 32'h12, 32'h12};
        logic [31:0] exp [4] = '{32'hFFFFFFDE, 32'h000000DE, 32'hFFFFDEAD, 32'h0000DEAD};
        do_req(1'b1, 3'b010, 32'h10, 32'hDEADBEEF, en, wen, din, ma);
        wait_rsp(lat, rd, er);
        for (int i = 0; i < 4; i++) begin
            do_req(1'b0, f3s[i], ads[i], 32'h0, en, wen, din, ma);
            wait_rsp(lat, rd, er);
            vec++;
            if (lat != 2 || er !== 1'b0 || rd !== exp[i]) begin
                errs++; $display("FAIL subload_%0d: lat=%0d err=%b rdata=%h, want 2 0 %h", i, lat, er, rd, exp[i]);
            end
        end
        do_req(1'b1, 3'b001, 32'h12, 32'h00007777, en, wen, din, ma);
        vec++;
        if (mem_we !== 1'b1 || mem_din !== 32'h7777BEEF) begin
            errs++; $display("FAIL sh_merge: we=%b din=%h, want 1 7777beef", mem_we, mem_din);
        end
        wait_rsp(lat, rd, er);
        do_req(1'b0, 3'b010, 32'h10, 32'h0, en, wen, din, ma);
        wait_rsp(lat, rd, er);
        vec++;
        if (rd !== 32'h7777BEEF) begin
            errs++; $display("FAIL sh_readback: rdata=%h, want 7777beef", rd);
        end
    endtask

    task automatic test_errors();
        logic en, wen, er; logic [31:0] din, rd; logic [AW-1:0] ma; int lat; int e0;
        logic        wes [5] = '{1'b1, 1'b0, 1'b0, 1'b1, 1'b1};
        logic [2:0]  f3s [5] = '{3'b001, 3'b010, 3'b011, 3'b100, 3'b010};
        logic [31:0] ads [5] = '{32'h11, 32'h12, 32'h10, 32'h10, 32'h13};
        e0 = en_cnt;
        for (int i = 0; i < 5; i++) begin
            do_req(wes[i], f3s[i], ads[i], 32'hFFFFFFFF, en, wen, din, ma);
            wait_rsp(lat, rd, er);
            vec++;
            if (lat != 1 || er !== 1'b1 || rd !== 32'h0 || en !== 1'b0) begin
                errs++; $display("FAIL err_%0d: lat=%0d err=%b rdata=%h en=%b, want 1 1 0 0", i, lat, er, rd, en);
            end
        end
        vec++;
        if (en_cnt != e0) begin
            errs++; $display("FAIL err_noaccess: enable cycles=%0d, want 0", en_cnt - e0);
        end
    endtask

    task automatic test_backpressure();
        logic en, wen, er; logic [31:0] din, rd; logic [AW-1:0] ma; int n; int bad;
        do_req(1'b0, 3'b010, 32'h10, 32'h0, en, wen, din, ma);
        n = 0;
        while (!rsp_valid && n < 20) begin
            @(posedge clk); #1; n++;
        end
        // A second request waiting while the response is stalled must be ignored.
        req_we = 1'b1; req_funct3 = 3'b010; req_addr = 32'h20; req_wdata = 32'hCAFEF00D; req_valid = 1'b1;
        bad = 0;
        for (int i = 0; i < 5; i++) begin
            #1;
            if (rsp_valid !== 1'b1 || rsp_rdata !== 32'h7777BEEF || rsp_err !== 1'b0 ||
                req_ready !== 1'b0 || mem_enable !== 1'b0) bad++;
            @(posedge clk); #1;
        end
        vec++;
        if (bad != 0) begin
            errs++; $display("FAIL stall_hold: %0d cycles unstable, want 0", bad);
        end
        req_valid = 1'b0;
        rsp_ready = 1'b1;
        @(posedge clk); #1;
        rsp_ready = 1'b0;
        vec++;
        if (rsp_valid !== 1'b0 || req_ready !== 1'b1 || ram[8] !== 32'h0) begin
            errs++; $display("FAIL stall_release: valid=%b ready=%b word8=%h, want 0 1 0", rsp_valid, req_ready, ram[8]);
        end
        do_req(1'b0, 3'b101, 32'h12, 32'h0, en, wen, din, ma);
        wait_rsp(n, rd, er);
        vec++;
        if (n != 2 || rd !== 32'h00007777) begin
            errs++; $display("FAIL stall_next: lat=%0d rdata=%h, want 2 00007777", n, rd);
        end
    endtask

    task automatic test_reset_in_merge();
        logic en, wen, er; logic [31:0] din, rd; logic [AW-1:0] ma; int lat; int w0;
        w0 = we_cnt;
        do_req(1'b1, 3'b000, 32'h10, 32'h00000055, en, wen, din, ma);
        rstn = 1'b0;
        #1;
        vec++;
        if (mem_we !== 1'b0 || mem_enable !== 1'b0 || rsp_valid !== 1'b0 || req_ready !== 1'b0) begin
            errs++; $display("FAIL merge_reset: we=%b en=%b valid=%b ready=%b, want 0 0 0 0",
                             mem_we, mem_enable, rsp_valid, req_ready);
        end
        @(posedge clk); #2;
        rstn = 1'b1;
        @(posedge clk); #1;
        vec++;
        if (we_cnt != w0 || rsp_valid !== 1'b0 || req_ready !== 1'b1) begin
            errs++; $display("FAIL merge_reset_idle: we_pulses=%0d valid=%b ready=%b, want 0 0 1",
                             we_cnt - w0, rsp_valid, req_ready);
        end
        do_req(1'b0, 3'b010, 32'h10, 32'h0, en, wen, din, ma);
        wait_rsp(lat, rd, er);
        vec++;
        if (rd !== 32'h7777BEEF || er !== 1'b0) begin
            errs++; $display("FAIL merge_reset_word: rdata=%h err=%b, want 7777beef 0", rd, er);
        end
    endtask

    initial begin
        test_reset();
        test_sw_lw();
        test_sb_merge();
        test_sub_loads();
        test_errors();
        test_backpressure();
        test_reset_in_merge();
        $display("== %0d vectors applied, %0d miscompares ==", vec, errs);
        $finish;
    end

endmodule

// File: doc/rip_dmem_rmw_ctrl.md
Name: rip_dmem_rmw_ctrl

Overview:
Load/store controller that sits directly upstream of the data-memory 2-read/1-write block RAM and drives its port 1 only; port 2 stays free for other users. The RAM supports only whole-line writes, so this block implements RV32 byte and halfword stores as a read-modify-write sequence. It also performs load byte/half extraction with sign or zero extension, and flags misaligned or illegal accesses. It connects to the memory stage of the pipeline through a valid/ready request channel and a valid/ready response channel.

Parameters:
ADDR_WIDTH, 10, RAM word-address width; the RAM depth is 2**ADDR_WIDTH words of 32 bits.

Ports:
clk  in  1  clock
rstn  in  1  asynchronous active-low reset
req_valid  in  1  request present
req_ready  out  1  request accepted when req_valid && req_ready at a clk edge
req_we  in  1  1 = store, 0 = load
req_funct3  in  3  RV32 funct3 (LB/LH/LW/LBU/LHU, SB/SH/SW)
req_addr  in  32  byte address
req_wdata  in  32  store data; low bytes are used for SB/SH
rsp_valid  out  1  response present
rsp_ready  in  1  response consumed when rsp_valid && rsp_ready
rsp_rdata  out  32  load result; 0 for stores and errors
rsp_err  out  1  misaligned or illegal funct3
mem_enable  out  1  RAM port-1 enable
mem_we  out  1  RAM port-1 write enable
mem_addr  out  ADDR_WIDTH  RAM word address = req_addr[ADDR_WIDTH+1:2]; upper address bits are ignored (wrap)
mem_din  out  32  RAM write data
mem_dout  in  32  RAM port-1 read data

Behaviour:
RAM contract:
- Port 1 has 1-cycle read latency and is read-first: the old data appears on a write cycle.
- mem_dout is valid in the cycle after the enable edge.

States: IDLE, LOAD, MERGE, RESP.

Reset (rstn low, asynchronous):
- state goes to IDLE.
- rsp_valid=0, rsp_rdata=0, rsp_err=0.
- All internal registers (address, funct3, byte offset, wdata) are cleared.
- req_ready=0 while rstn is low.

Outputs per state:
- req_ready = (state==IDLE) && rstn.
- mem_* outputs are combinational and are 0 unless stated below.

IDLE, request accepted:
- Error case (LH/LHU/SH with addr[0]=1; LW/SW with addr[1:0]!=0; funct3 not in the legal set for req_we):
  - No RAM access: mem_enable stays 0.
  - Go to RESP with rsp_err=1, rsp_rdata=0.
- SW:
  - Same cycle: mem_enable=1, mem_we=1, mem_din=req_wdata.
  - Go to RESP with rsp_err=0.
- Load, SB or SH:
  - Same cycle: mem_enable=1, mem_we=0.
  - Latch address, funct3, addr[1:0] and wdata.
  - Loads go to LOAD; SB/SH go to MERGE.

LOAD:
- Extract the lane from mem_dout by the latched offset.
- Sign-extend for LB/LH; zero-extend for LBU/LHU; pass through for LW.
- Register the result into rsp_rdata and go to RESP.

MERGE:
- mem_enable=1, mem_we=1, mem_addr = latched address.
- mem_din = mem_dout with byte lane (SB) or half lane (SH) replaced by wdata[7:0] / wdata[15:0].
- Go to RESP with rsp_err=0, rsp_rdata=0.

RESP:
- rsp_valid=1; rsp_rdata and rsp_err are held stable until rsp_ready.
- On rsp_ready go to IDLE. The next request can be accepted in the following cycle; responses never overlap.

Latency, request accept edge to first rsp_valid cycle:
- SW and errors: 1 cycle.
- Loads, SB, SH: 2 cycles.

Guarantees:
- mem_we is asserted for exactly one cycle per non-error store.
- Reset asserted during MERGE, before the clock edge: no write reaches RAM.
- rsp_ready while rsp_valid=0 is ignored.
- req_valid while not ready is ignored; the requester holds the request.

Decomposition:
Package rip_lsu_pkg:
- funct3 localparams (F3_B=3'b000, F3_H=3'b001, F3_W=3'b010, F3_BU=3'b100, F3_HU=3'b101).
- State enum type.

Sub-module rip_lsu_align (purely combinational):
- Load extract and extend (funct3, offset, word -> result).
- Store merge (funct3, offset, old word, wdata -> new word).
- Misalignment/illegal check.
- Instantiated once; testable standalone.

Test Plan:
1. SW addr 0x10 data 0xDEADBEEF, then LW 0x10 -> write to word 4 in the accept cycle, rsp next cycle err=0; LW rsp_rdata=0xDEADBEEF two cycles after accept.
2. SB addr 0x11 wdata 0x123456AA over test 1 -> exactly one mem_we pulse (MERGE) with mem_din=0xDEADAAEF; LW 0x10 then returns 0xDEADAAEF.
3. Word 4 = 0xDEADBEEF:
   - LB 0x13 -> 0xFFFFFFDE
   - LBU 0x13 -> 0x000000DE
   - LH 0x12 -> 0xFFFFDEAD
   - LHU 0x12 -> 0x0000DEAD
   - SH 0x12 data 0x00007777, then LW -> 0x7777BEEF
4. SH 0x11, LW 0x12, load funct3=3'b011 -> each gives rsp_err=1, rsp_rdata=0, rsp one cycle after accept; mem_enable never asserted.
5. LW with rsp_ready low for 5 cycles -> rsp_valid, rsp_rdata, rsp_err stable and req_ready=0 throughout; rsp_ready=1 -> IDLE next cycle, new request accepted.
6. rstn pulled low in the MERGE cycle of an SB -> no write, rsp_valid=0, state IDLE; after release, LW returns the unchanged word.
